inst_mem_block: RTL and testbench

- Word-addressable 1024 x 32-bit simple dual-port memory (one write port, one read port) for the RISC-V/MIPS32 instruction store.
- Writes are loaded by a loader/testbench; reads are issued by instruction fetch.
- After reset, a built-in clear sequencer zeroes the array before normal operation.
- Synchronous write, registered read, single clock domain.

---
 rtl/inst_mem_block.sv | 244 ++++++++++++++++++++++++
 tb/tb_inst_mem_block.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_block.sv
// -----------------------------------------------------------------------------
// inst_mem_block
//
// Instruction store: a word-addressable DEPTH x DATA_W simple dual-port memory.
// There is one write port, used by the loader, and one read port, used by
// instruction fetch.
//
// After reset, a built-in clear sequencer writes zero to every word, one word
// per cycle. When the last word is cleared, init_done rises and normal
// operation begins.
//
// Writes are synchronous and byte-masked. The read data is registered, so a
// read returns its word one cycle after the address is presented. When the
// read and write ports hit the same address on the same edge, the read is
// write-first: it returns the merged new word.
//
// Ports
//   clk        in   1         clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   wr_en      in   1         write enable (honoured only once init_done=1)
//   byte_en    in   DATA_W/8  per-byte write mask, bit i -> data_in[8i+7:8i]
//   addr_w     in   ADDR_W    write word address
//   data_in    in   DATA_W    write data
//   addr_r     in   ADDR_W    read word address
//   data_out   out  DATA_W    registered read data
//   init_done  out  1         high once the post-reset clear has finished
//
// Optional build macro INST_MEM_PARITY_EN
//   When defined, each word stores an extra even-parity bit, computed over
//   the merged written word. The clear sequence writes parity 0.
//   An output parity_err is added. It is registered alongside data_out and
//   is high when the stored parity bit disagrees with the stored data of the
//   word being read.
//
//   A simulation-only input par_inject is also available. It is present only
//   when INST_MEM_PARITY_INJECT is defined as well. When asserted, it flips
//   the parity bit being written, so that error detection can be exercised.
//
// DEPTH must equal 2**ADDR_W. The clear pointer relies on this to cover
// every word.
//
// FSM state is held in state_q (ST_CLEAR / ST_READY).
//
// Handshake: this block has no valid/ready handshake. A read is performed
// on every edge while in ST_READY. data_out always reflects the address
// sampled on the previous edge.
// -----------------------------------------------------------------------------
module inst_mem_block #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [ADDR_W-1:0]   addr_w,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [ADDR_W-1:0]   addr_r,
  output logic [DATA_W-1:0]   data_out,
  output logic                init_done
`ifdef INST_MEM_PARITY_EN
  ,
  output logic                parity_err
`ifdef INST_MEM_PARITY_INJECT
  ,
  input  logic                par_inject
`endif
`endif
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;
  logic              init_done_q, init_done_d;
  logic [DATA_W-1:0] data_out_q,  data_out_d;

  // Write-port request seen by the array
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // User write path
  logic              user_we;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic              collide;

  // The stored word is read here so that masked bytes keep their old value.
  // The merged result also serves as the write-first bypass for a same-address
  // read.
  always_comb begin
    old_word    = mem[addr_w];
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) begin
        merged_word[8*i +: 8] = data_in[8*i +: 8];
      end
    end
  end

  // An all-zero mask is treated as no write at all.
  // The write path is also disabled until the array has been cleared.
  assign user_we = (state_q == ST_READY) && wr_en && (|byte_en);
  assign collide = user_we && (addr_w == addr_r);

`ifdef INST_MEM_PARITY_EN
  logic              par_mem [DEPTH];
  logic              par_wbit;
  logic              parity_err_q, parity_err_d;
  logic              inject_bit;

`ifdef INST_MEM_PARITY_INJECT
  assign inject_bit = par_inject;
`else
  assign inject_bit = 1'b0;
`endif
`endif

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q;
    data_out_d  = data_out_q;
    mem_we      = 1'b0;
    mem_waddr   = ptr_q;
    mem_wdata   = '0;
`ifdef INST_MEM_PARITY_EN
    par_wbit     = 1'b0;
    parity_err_d = parity_err_q;
`endif

    case (state_q)
      ST_CLEAR: begin
        // One word is zeroed per cycle. wr_en is ignored, and data_out keeps
        // its reset value of 0.
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_ADDR) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end

      ST_READY: begin
        mem_we    = user_we;
        mem_waddr = addr_w;
        mem_wdata = merged_word;
`ifdef INST_MEM_PARITY_EN
        par_wbit  = (^merged_word) ^ inject_bit;
`endif
        if (collide) begin
          data_out_d = merged_word;
`ifdef INST_MEM_PARITY_EN
          parity_err_d = (^merged_word) ^ par_wbit;
`endif
        end else begin
          data_out_d = mem[addr_r];
`ifdef INST_MEM_PARITY_EN
          parity_err_d = (^mem[addr_r]) ^ par_mem[addr_r];
`endif
        end
      end

      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
      data_out_q  <= data_out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Array write port
  //
  // The array itself is not reset. Contents are zeroed by the clear
  // sequencer instead.
  //
  // Gating with rst_n drops any write that coincides with reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

`ifdef INST_MEM_PARITY_EN
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      par_mem[mem_waddr] <= par_wbit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign data_out  = data_out_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_inst_mem_block.sv
module tb_inst_mem_block;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic          wr_en   = 1'b0;
  logic [DW/8-1:0] byte_en = '0;
  logic [AW-1:0] addr_w  = '0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] addr_r  = '0;
  logic [DW-1:0] data_out;
  logic          init_done;
`ifdef INST_MEM_PARITY_EN
  logic          parity_err;
`ifdef INST_MEM_PARITY_INJECT
  logic          par_inject = 1'b0;
`endif
`endif

  // Marks a cycle whose read result must be checked on the next edge
  logic rd_req = 1'b0;

  inst_mem_block #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .byte_en   (byte_en),
    .addr_w    (addr_w),
    .data_in   (data_in),
    .addr_r    (addr_r),
    .data_out  (data_out),
    .init_done (init_done)
`ifdef INST_MEM_PARITY_EN
    ,
    .parity_err(parity_err)
`ifdef INST_MEM_PARITY_INJECT
    ,
    .par_inject(par_inject)
`endif
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected word one edge after each issued read
  always @(posedge clk) begin
    if (rd_req) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected actual=%h expected=none", data_out);
      end else begin
        check($sformatf("read_addr_%0d", exp_addr_q.pop_front()), data_out, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle();
    @(negedge clk);
    wr_en   = 1'b0;
    byte_en = '0;
    rd_req  = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    @(negedge clk);
    wr_en   = 1'b1;
    addr_w  = a;
    data_in = d;
    byte_en = be;
    rd_req  = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    @(negedge clk);
    wr_en   = 1'b0;
    byte_en = '0;
    addr_r  = a;
    rd_req  = 1'b1;
    exp_q.push_back(exp);
    exp_addr_q.push_back(a);
  endtask

  task automatic wr_rd(input logic [AW-1:0] wa, input logic [DW-1:0] d, input logic [3:0] be,
                       input logic [AW-1:0] ra, input logic [DW-1:0] exp);
    @(negedge clk);
    wr_en   = 1'b1;
    addr_w  = wa;
    data_in = d;
    byte_en = be;
    addr_r  = ra;
    rd_req  = 1'b1;
    exp_q.push_back(exp);
    exp_addr_q.push_back(ra);
  endtask

  // Counts rising edges from the call until init_done is seen high,
  // with a 2000-cycle bound
  task automatic wait_init(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!init_done && n < 2000);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_data_out", data_out, 32'h0);
    check("reset_init_done", {31'b0, init_done}, 32'h0);
    rst_n = 1'b1;
    wait_init(n);
    check("init_latency", n, 32'd1024);

    rd(10'd5, 32'h0000_0000);

    // Basic full-word writes, then read them back
    wr(10'd0, 32'hAAAA_BBBB, 4'hF);
    wr(10'd1, 32'h1234_5678, 4'hF);
    wr(10'd2, 32'hDEAD_BEEF, 4'hF);
    rd(10'd0, 32'hAAAA_BBBB);
    rd(10'd1, 32'h1234_5678);
    rd(10'd2, 32'hDEAD_BEEF);

    // Overwrite
    wr(10'd1, 32'hFFFF_0000, 4'hF);
    rd(10'd1, 32'hFFFF_0000);

    // Byte mask 0101: bytes 0 and 2 come from the new data
    wr(10'd3, 32'h1122_3344, 4'hF);
    wr(10'd3, 32'hAABB_CCDD, 4'b0101);
    rd(10'd3, 32'h11BB_33DD);

    // An all-zero mask writes nothing
    wr(10'd4, 32'h5555_5555, 4'b0000);
    rd(10'd4, 32'h0000_0000);

    // Same-address collision: the read is write-first
    wr_rd(10'd7, 32'hCAFE_F00D, 4'hF, 10'd7, 32'hCAFE_F00D);
    rd(10'd7, 32'hCAFE_F00D);

    // Partial-mask collision returns the merged word
    wr_rd(10'd3, 32'h9900_0000, 4'b1000, 10'd3, 32'h99BB_33DD);

    // Different addresses on the same edge are independent
    wr_rd(10'd8, 32'h0102_0304, 4'hF, 10'd2, 32'hDEAD_BEEF);
    rd(10'd8, 32'h0102_0304);

    // Top address
    wr(10'd1023, 32'h0BAD_F00D, 4'hF);
    rd(10'd1023, 32'h0BAD_F00D);
    idle();
    @(posedge clk);
    #1 check("hold_data_out", data_out, 32'h0BAD_F00D);

    // Asynchronous reset, not aligned to the clock
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_data_out", data_out, 32'h0);
    check("midreset_init_done", {31'b0, init_done}, 32'h0);
    addr_r = 10'd1;
    @(posedge clk);
    #4 rst_n = 1'b1;

    // Clear sequence. Write pulses to addr 2 arrive after the clear has
    // already passed addr 2, so they must be ignored.
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n >= 100 && n <= 104) begin
        wr_en   = 1'b1;
        addr_w  = 10'd2;
        data_in = 32'hF00D_F00D;
        byte_en = 4'hF;
      end else begin
        wr_en   = 1'b0;
        byte_en = '0;
      end
      if (n == 50 || n == 500 || n == 1000) begin
        check("clear_data_out", data_out, 32'h0);
      end
    end while (!init_done && n < 2000);
    check("reinit_latency", n, 32'd1024);

    rd(10'd2, 32'h0000_0000);
    rd(10'd1, 32'h0000_0000);
    rd(10'd3, 32'h0000_0000);
    rd(10'd1023, 32'h0000_0000);
    idle();
    repeat (3) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
